// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main control FSM for the multicycle MIPS core.
// It decodes op/funct, sequences the datapath through fetch, decode,
// execute, memory and writeback steps, and stalls on mem_ready.
// Optional feature macro: MIPS_CTRL_ZEROEXT_EN enables andi/ori with a
// zero-extended immediate (extsel=1). Without it, those opcodes are illegal
// and extsel is constant 0.
// Ports:
//   clk, reset_n           clock, async active-low reset
//   op, funct              instruction fields from the IR
//   zero                   ALU zero flag (beq)
//   mem_ready              memory completes the access this cycle
//   pcen, irwrite          PC / IR enables
//   memwrite, regwrite     memory write strobe / register file write enable
//   iord, regdst, memtoreg address, destination and writeback selects
//   alusrca, alusrcb       ALU operand selects
//   pcsrc, alucontrol      next-PC select / ALU operation
//   extsel                 0 = sign-extend, 1 = zero-extend immediate
//   illegal_op             one-cycle pulse on unsupported op/funct
//   state                  current state, for debug
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       extsel,
  output logic       illegal_op,
  output logic [3:0] state
);
  localparam int unsigned SW = 4;

  localparam logic [SW-1:0] S_FETCH   = 4'd0;
  localparam logic [SW-1:0] S_DECODE  = 4'd1;
  localparam logic [SW-1:0] S_MEMADR  = 4'd2;
  localparam logic [SW-1:0] S_MEMRD   = 4'd3;
  localparam logic [SW-1:0] S_MEMWB   = 4'd4;
  localparam logic [SW-1:0] S_MEMWR   = 4'd5;
  localparam logic [SW-1:0] S_RTYPEEX = 4'd6;
  localparam logic [SW-1:0] S_ALUWB   = 4'd7;
  localparam logic [SW-1:0] S_BEQEX   = 4'd8;
  localparam logic [SW-1:0] S_ADDIEX  = 4'd9;
  localparam logic [SW-1:0] S_IMMWB   = 4'd10;
  localparam logic [SW-1:0] S_JEX     = 4'd11;
  localparam logic [SW-1:0] S_ANDIEX  = 4'd12;
  localparam logic [SW-1:0] S_ORIEX   = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_CTRL_ZEROEXT_EN
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
`endif

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [SW-1:0] state_q, state_d;
  logic [SW-1:0] dec_next;
  logic          dec_ok;
  logic [2:0]    rtype_alu;
  logic          rtype_ok;

  // Opcode decode: execute-state target and legality
  always_comb begin
    dec_next = S_FETCH;
    dec_ok   = 1'b1;
    case (op)
      OP_LW, OP_SW: dec_next = S_MEMADR;
      OP_RTYPE:     dec_next = S_RTYPEEX;
      OP_BEQ:       dec_next = S_BEQEX;
      OP_ADDI:      dec_next = S_ADDIEX;
      OP_J:         dec_next = S_JEX;
`ifdef MIPS_CTRL_ZEROEXT_EN
      OP_ANDI:      dec_next = S_ANDIEX;
      OP_ORI:       dec_next = S_ORIEX;
`endif
      default:      dec_ok   = 1'b0;
    endcase
  end

  // R-type funct decode
  always_comb begin
    rtype_alu = ALU_ADD;
    rtype_ok  = 1'b1;
    case (funct)
      6'b100000: rtype_alu = ALU_ADD;
      6'b100010: rtype_alu = ALU_SUB;
      6'b100100: rtype_alu = ALU_AND;
      6'b100101: rtype_alu = ALU_OR;
      6'b101010: rtype_alu = ALU_SLT;
      default:   rtype_ok  = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:  state_d = dec_next;
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_d = rtype_ok ? S_ALUWB : S_FETCH;
      S_ADDIEX, S_ANDIEX, S_ORIEX: state_d = S_IMMWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // Output decode; everything held at 0 while reset is asserted
  always_comb begin
    pcen       = 1'b0;
    irwrite    = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b000;
    extsel     = 1'b0;
    illegal_op = 1'b0;
    if (reset_n) begin
      case (state_q)
        S_FETCH: begin
          alusrcb    = 2'b01;
          alucontrol = ALU_ADD;
          irwrite    = mem_ready;
          pcen       = mem_ready;  // one PC advance per fetch, on completion
        end
        S_DECODE: begin
          alusrcb    = 2'b11;
          alucontrol = ALU_ADD;
          illegal_op = ~dec_ok;
        end
        S_MEMADR: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          alucontrol = ALU_ADD;
        end
        S_MEMRD: iord = 1'b1;
        S_MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
        end
        S_MEMWR: begin
          iord     = 1'b1;
          memwrite = 1'b1;
        end
        S_RTYPEEX: begin
          alusrca    = 1'b1;
          alucontrol = rtype_alu;
          illegal_op = ~rtype_ok;
        end
        S_ALUWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        S_BEQEX: begin
          alusrca    = 1'b1;
          alucontrol = ALU_SUB;
          pcsrc      = 2'b01;
          pcen       = zero;
        end
        S_ADDIEX: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          alucontrol = ALU_ADD;
        end
        S_ANDIEX: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          alucontrol = ALU_AND;
`ifdef MIPS_CTRL_ZEROEXT_EN
          extsel     = 1'b1;
`endif
        end
        S_ORIEX: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          alucontrol = ALU_OR;
`ifdef MIPS_CTRL_ZEROEXT_EN
          extsel     = 1'b1;
`endif
        end
        S_IMMWB: regwrite = 1'b1;
        S_JEX: begin
          pcsrc = 2'b10;
          pcen  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class
// through its state sequence and checks the control outputs per cycle.
module tb_mips_multicycle_ctrl;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pcen, irwrite, memwrite, regwrite, iord, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       extsel, illegal_op;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite),
    .regwrite(regwrite), .iord(iord), .regdst(regdst), .memtoreg(memtoreg),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .extsel(extsel), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  logic [20:0] outs;
  assign outs = {pcen, irwrite, memwrite, regwrite, iord, regdst, memtoreg, alusrca,
                 alusrcb, pcsrc, alucontrol, extsel, illegal_op, state};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mem_ready = 1'b1; op = 6'b100011; funct = 6'd0; zero = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (outs !== 21'd0) begin n_fail++; $display("FAIL reset_outs got=%h exp=0", outs); end
    mem_ready = 1'b0;
    step();
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL rst_state got=%0d exp=0", state); end
    n_checks++; if ({pcen, irwrite} !== 2'b00) begin n_fail++; $display("FAIL rst_fetch_stall got=%b exp=00", {pcen, irwrite}); end
    n_checks++; if ({alusrcb, alucontrol, iord, alusrca} !== 7'b01_010_0_0) begin n_fail++; $display("FAIL rst_fetch_mux got=%b exp=0101000", {alusrcb, alucontrol, iord, alusrca}); end
    step();
  endtask

  task automatic test_lw();
    logic [3:0] st [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    op = 6'b100011;
    for (int i = 0; i < 6; i++) begin
      mem_ready = (i < 5);
      @(negedge clk);
      n_checks++; if (state !== st[i]) begin n_fail++; $display("FAIL lw_state cyc=%0d got=%0d exp=%0d", i, state, st[i]); end
      n_checks++; if ({regwrite, memtoreg} !== {2{i == 4}}) begin n_fail++; $display("FAIL lw_wb cyc=%0d got=%b", i, {regwrite, memtoreg}); end
      if (i == 0) begin
        n_checks++; if ({irwrite, pcen} !== 2'b11) begin n_fail++; $display("FAIL lw_fetch got=%b exp=11", {irwrite, pcen}); end
      end
      if (i == 1) begin
        n_checks++; if ({alusrca, alusrcb, alucontrol} !== 6'b0_11_010) begin n_fail++; $display("FAIL lw_decode got=%b exp=011010", {alusrca, alusrcb, alucontrol}); end
      end
      if (i == 2) begin
        n_checks++; if ({alusrca, alusrcb, extsel} !== 4'b1_10_0) begin n_fail++; $display("FAIL lw_memadr got=%b exp=1100", {alusrca, alusrcb, extsel}); end
      end
      if (i == 3) begin
        n_checks++; if (iord !== 1'b1) begin n_fail++; $display("FAIL lw_iord got=%b exp=1", iord); end
      end
      step();
    end
  endtask

  task automatic test_sw_stall();
    logic [3:0] st [8] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
    logic       mr [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int wr_cycles = 0;
    op = 6'b101011;
    for (int i = 0; i < 8; i++) begin
      mem_ready = mr[i];
      @(negedge clk);
      if (memwrite === 1'b1) wr_cycles++;
      n_checks++; if (state !== st[i]) begin n_fail++; $display("FAIL sw_state cyc=%0d got=%0d exp=%0d", i, state, st[i]); end
      n_checks++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL sw_regwrite cyc=%0d got=%b exp=0", i, regwrite); end
      if (st[i] == 4'd5) begin
        n_checks++; if (iord !== 1'b1) begin n_fail++; $display("FAIL sw_iord cyc=%0d got=%b exp=1", i, iord); end
      end
      if (i >= 1 && i <= 6) begin
        n_checks++; if (pcen !== 1'b0) begin n_fail++; $display("FAIL sw_pcen cyc=%0d got=%b exp=0", i, pcen); end
      end
      step();
    end
    n_checks++; if (wr_cycles != 4) begin n_fail++; $display("FAIL sw_memwrite_cycles got=%0d exp=4", wr_cycles); end
  endtask

  task automatic test_beq();
    op = 6'b000100;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      mem_ready = 1'b1;
      step();
      step();
      @(negedge clk);
      n_checks++; if (state !== 4'd8) begin n_fail++; $display("FAIL beq_state z=%0d got=%0d exp=8", z, state); end
      n_checks++; if ({pcen, pcsrc, alucontrol} !== {z[0], 2'b01, 3'b110}) begin n_fail++; $display("FAIL beq_ex z=%0d got=%b exp=%b", z, {pcen, pcsrc, alucontrol}, {z[0], 5'b01110}); end
      mem_ready = 1'b0;
      step();
      @(negedge clk);
      n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL beq_return z=%0d got=%0d exp=0", z, state); end
      step();
    end
  endtask

  task automatic test_rtype();
    op = 6'b000000; funct = 6'b100010; mem_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    n_checks++; if ({state, alucontrol, illegal_op, alusrca, alusrcb} !== {4'd6, 3'b110, 1'b0, 1'b1, 2'b00}) begin n_fail++; $display("FAIL rtype_ex got=%b", {state, alucontrol, illegal_op, alusrca, alusrcb}); end
    step();
    @(negedge clk);
    n_checks++; if ({state, regdst, regwrite, memtoreg} !== {4'd7, 3'b110}) begin n_fail++; $display("FAIL rtype_wb got=%b exp=0111110", {state, regdst, regwrite, memtoreg}); end
    mem_ready = 1'b0;
    step();
    funct = 6'b111111; mem_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    n_checks++; if ({state, illegal_op} !== {4'd6, 1'b1}) begin n_fail++; $display("FAIL rtype_badfunct got=%b exp=01101", {state, illegal_op}); end
    mem_ready = 1'b0;
    step();
    @(negedge clk);
    n_checks++; if ({state, regwrite, illegal_op} !== 6'd0) begin n_fail++; $display("FAIL rtype_skip_wb got=%b exp=000000", {state, regwrite, illegal_op}); end
    step();
  endtask

  task automatic test_imm_and_jump();
    op = 6'b001000; mem_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    n_checks++; if ({state, alusrcb, alucontrol, extsel} !== {4'd9, 2'b10, 3'b010, 1'b0}) begin n_fail++; $display("FAIL addi_ex got=%b", {state, alusrcb, alucontrol, extsel}); end
    step();
    @(negedge clk);
    n_checks++; if ({state, regwrite, regdst, memtoreg} !== {4'd10, 3'b100}) begin n_fail++; $display("FAIL addi_wb got=%b", {state, regwrite, regdst, memtoreg}); end
    mem_ready = 1'b0;
    step();
    op = 6'b000010; mem_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    n_checks++; if ({state, pcen, pcsrc} !== {4'd11, 1'b1, 2'b10}) begin n_fail++; $display("FAIL j_ex got=%b", {state, pcen, pcsrc}); end
    mem_ready = 1'b0;
    step();
    @(negedge clk);
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL j_return got=%0d exp=0", state); end
    step();
  endtask

  task automatic test_ori();
    op = 6'b001101; mem_ready = 1'b1;
    step();
    @(negedge clk);
`ifdef MIPS_CTRL_ZEROEXT_EN
    n_checks++; if ({state, illegal_op, extsel} !== {4'd1, 2'b00}) begin n_fail++; $display("FAIL ori_decode got=%b", {state, illegal_op, extsel}); end
    step();
    @(negedge clk);
    n_checks++; if ({state, extsel, alucontrol, alusrcb} !== {4'd13, 1'b1, 3'b001, 2'b10}) begin n_fail++; $display("FAIL ori_ex got=%b", {state, extsel, alucontrol, alusrcb}); end
    step();
    @(negedge clk);
    n_checks++; if ({state, regwrite, extsel} !== {4'd10, 2'b10}) begin n_fail++; $display("FAIL ori_wb got=%b", {state, regwrite, extsel}); end
`else
    n_checks++; if ({state, illegal_op, extsel} !== {4'd1, 2'b10}) begin n_fail++; $display("FAIL ori_illegal got=%b exp=000110", {state, illegal_op, extsel}); end
`endif
    mem_ready = 1'b0;
    step();
    @(negedge clk);
    n_checks++; if ({state, illegal_op} !== 5'd0) begin n_fail++; $display("FAIL ori_return got=%b exp=00000", {state, illegal_op}); end
    op = 6'b111111;
    mem_ready = 1'b1;
    step();
    @(negedge clk);
    n_checks++; if ({state, illegal_op} !== {4'd1, 1'b1}) begin n_fail++; $display("FAIL badop_decode got=%b exp=00011", {state, illegal_op}); end
    mem_ready = 1'b0;
    step();
    @(negedge clk);
    n_checks++; if ({state, illegal_op} !== 5'd0) begin n_fail++; $display("FAIL badop_return got=%b exp=00000", {state, illegal_op}); end
    step();
  endtask

  task automatic test_reset_midinstr();
    op = 6'b101011; mem_ready = 1'b1;
    step();
    step();
    mem_ready = 1'b0;
    step();
    @(negedge clk);
    n_checks++; if ({state, memwrite} !== {4'd5, 1'b1}) begin n_fail++; $display("FAIL mid_memwr got=%b exp=01011", {state, memwrite}); end
    #1 reset_n = 1'b0;
    #1;
    n_checks++; if ({state, memwrite, regwrite} !== 6'd0) begin n_fail++; $display("FAIL mid_reset got=%b exp=000000", {state, memwrite, regwrite}); end
    step();
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if ({state, pcen, irwrite} !== 6'd0) begin n_fail++; $display("FAIL mid_refetch_wait got=%b exp=000000", {state, pcen, irwrite}); end
    step();
    mem_ready = 1'b1;
    @(negedge clk);
    n_checks++; if ({state, pcen, irwrite} !== {4'd0, 2'b11}) begin n_fail++; $display("FAIL mid_refetch got=%b exp=000011", {state, pcen, irwrite}); end
    step();
    @(negedge clk);
    n_checks++; if (state !== 4'd1) begin n_fail++; $display("FAIL mid_decode got=%0d exp=1", state); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lw();
    test_sw_stall();
    test_beq();
    test_rtype();
    test_imm_and_jump();
    test_ori();
    test_reset_midinstr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
